// File: rtl/cpu_defs.sv
// Shared definitions for the 16-bit CPU front end: word/address widths, reset PC
// and the fetch state encoding.
package cpu_defs;

   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h3000;

   typedef enum logic {
      FS_RUN   = 1'b0,
      FS_FLUSH = 1'b1
   } fetch_state_e;

   // Prefetch queue entry layout: instruction in the upper half, its address below.
   function automatic logic [WORD_W+ADDR_W-1:0] pack_entry(input logic [WORD_W-1:0] inst,
                                                          input logic [ADDR_W-1:0] pc);
      return {inst, pc};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with synchronous flush and an occupancy count; rdata shows the
// head entry combinationally and is only meaningful while empty is low.
module fetch_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 push,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 pop,
   output logic [WIDTH-1:0]     rdata,
   output logic [(DEPTH > 1 ? $clog2(DEPTH) : 1):0] count,
   output logic                 empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == (AW + 1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full queue is legal only when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: sequential PC generation, in-order imem requests and a
// prefetch queue feeding decode. Build with FETCH_PERF_EN to get the fetch_cnt counter.
module fetch_prefetch_unit
   import cpu_defs::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter int                MAX_OUT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redir_valid,
   input  logic [ADDR_W-1:0] redir_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [WORD_W-1:0] dec_inst,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [31:0]       fetch_cnt
);

   localparam int QAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int TCW = TAW + 1;

   fetch_state_e             state_q, state_d;
   logic [ADDR_W-1:0]        pc_q, pc_d;
   logic [TCW-1:0]           discard_q, discard_d;
   logic                     issue;
   logic                     q_push;
   logic                     q_flush;
   logic                     q_pop;
   logic [WORD_W+ADDR_W-1:0] q_rdata;
   logic [QAW:0]             q_count;
   logic                     q_empty;
   logic [ADDR_W-1:0]        t_rdata;
   logic [TCW-1:0]           t_count;
   logic                     t_empty;
   logic                     resp_take;
   logic                     credit_ok;

   // Decode handshake: an entry transfers on a rising edge where dec_valid && dec_ready;
   // dec_valid and the dec_* payload depend only on the queue head, never on dec_ready.
   assign q_pop     = dec_valid && dec_ready;
   assign resp_take = imem_rvalid && !t_empty;
   assign credit_ok = (32'(q_count) + 32'(t_count) < DEPTH) && (32'(t_count) < MAX_OUT);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      discard_d = discard_q;
      issue     = 1'b0;
      q_push    = 1'b0;
      q_flush   = 1'b0;
      if (redir_valid) begin
         // A response arriving with the redirect belongs to the old stream.
         q_flush   = 1'b1;
         pc_d      = redir_pc;
         discard_d = t_count - TCW'(resp_take);
         state_d   = (discard_d != '0) ? FS_FLUSH : FS_RUN;
      end else begin
         unique case (state_q)
            FS_RUN: begin
               issue  = credit_ok;
               q_push = resp_take;
               if (issue) pc_d = pc_q + 1'b1;
            end
            FS_FLUSH: begin
               if (resp_take) begin
                  discard_d = discard_q - 1'b1;
                  if (discard_q == TCW'(1)) state_d = FS_RUN;
               end
            end
            default: state_d = FS_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FS_RUN;
         pc_q      <= RESET_PC;
         discard_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
      end
   end

   // Request addresses travel alongside the in-flight reads so each returned word
   // is tagged with its own PC.
   fetch_queue #(.WIDTH(ADDR_W), .DEPTH(MAX_OUT)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (issue),
      .wdata (pc_q),
      .pop   (resp_take),
      .rdata (t_rdata),
      .count (t_count),
      .empty (t_empty)
   );

   fetch_queue #(.WIDTH(WORD_W + ADDR_W), .DEPTH(DEPTH)) u_prefetch_q (
      .clk   (clk),
      .rst   (rst),
      .flush (q_flush),
      .push  (q_push),
      .wdata (pack_entry(imem_rdata, t_rdata)),
      .pop   (q_pop),
      .rdata (q_rdata),
      .count (q_count),
      .empty (q_empty)
   );

   assign imem_req  = issue && !rst;
   assign imem_addr = pc_q;
   assign dec_valid = !q_empty;
   assign dec_inst  = q_empty ? '0 : q_rdata[WORD_W+ADDR_W-1:ADDR_W];
   assign dec_pc    = q_empty ? '0 : q_rdata[ADDR_W-1:0];

`ifdef FETCH_PERF_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (q_pop) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign fetch_cnt = cnt_q;
`else
   assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: in-order memory model with variable
// latency and a scoreboard of expected {inst, pc} pairs in fetch order.
module tb_fetch_prefetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        redir_valid;
   logic [15:0] redir_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        dec_valid;
   logic        dec_ready;
   logic [15:0] dec_inst;
   logic [15:0] dec_pc;
   logic [31:0] fetch_cnt;

   always #5 clk = ~clk;

   fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h3000), .MAX_OUT(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_inst    (dec_inst),
      .dec_pc      (dec_pc),
      .fetch_cnt   (fetch_cnt)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   int          last_due = 0;
   logic [15:0] mem_data[$];
   int          mem_due[$];
   logic [31:0] exp_q[$];
   logic [15:0] exp_fetch_pc;
   int          drop_left = 0;
   bit          first_pend = 0;
   logic [15:0] first_pc;
   int          hs_since_rst = 0;
   int          hs_total = 0;
   bit          saw_zero = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_EN
      return 32'(hs_since_rst);
`else
      return 32'h0;
`endif
   endfunction

   // One clock cycle: drive memory response, sample outputs, update models, clock.
   task automatic tick();
      logic [31:0] e;
      logic [15:0] d;
      int          t;
      int          due;
      if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
         d = mem_data.pop_front();
         t = mem_due.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = d;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 16'($urandom_range(0, 65535));
      end
      #1;
      if (drop_left > 0) begin
         chk("flush_no_req", {31'h0, imem_req}, 32'h0);
         chk("flush_empty", {31'h0, dec_valid}, 32'h0);
      end
      if (redir_valid) chk("redir_no_req", {31'h0, imem_req}, 32'h0);
      if (imem_req) begin
         chk("req_addr", {16'h0, imem_addr}, {16'h0, exp_fetch_pc});
         due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         last_due = due;
         mem_data.push_back(imem_addr ^ 16'hA5A5);
         mem_due.push_back(due);
         exp_q.push_back({exp_fetch_pc ^ 16'hA5A5, exp_fetch_pc});
         exp_fetch_pc = exp_fetch_pc + 16'h1;
      end
      if (dec_valid && dec_ready) begin
         hs_since_rst++;
         hs_total++;
         chk("dec_expected", {31'h0, exp_q.size() != 0}, 32'h1);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         chk("dec_pc", {16'h0, dec_pc}, {16'h0, e[15:0]});
         chk("dec_inst", {16'h0, dec_inst}, {16'h0, e[31:16]});
         if (first_pend) chk("first_pc", {16'h0, dec_pc}, {16'h0, first_pc});
         first_pend = 0;
         if (dec_pc == 16'h0000) saw_zero = 1;
      end
      if (redir_valid) begin
         exp_q.delete();
         exp_fetch_pc = redir_pc;
         drop_left    = mem_due.size();
         first_pend   = 1;
         first_pc     = redir_pc;
      end else if (imem_rvalid && drop_left > 0) begin
         drop_left--;
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("fetch_cnt", fetch_cnt, exp_cnt());
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      redir_valid = 1'b0;
      imem_rvalid = 1'b0;
      mem_data.delete();
      mem_due.delete();
      exp_q.delete();
      drop_left = 0;
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
      chk("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
      chk("rst_dec_pc", {16'h0, dec_pc}, 32'h0);
      chk("rst_dec_inst", {16'h0, dec_inst}, 32'h0);
      chk("rst_fetch_cnt", fetch_cnt, 32'h0);
      @(posedge clk);
      #1;
      cyc++;
      rst          = 1'b0;
      exp_fetch_pc = 16'h3000;
      hs_since_rst = 0;
      first_pend   = 1;
      first_pc     = 16'h3000;
      last_due     = cyc;
   endtask

   initial begin
      int n0;
      rst         = 1'b1;
      redir_valid = 1'b0;
      redir_pc    = 16'h0;
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0;
      dec_ready   = 1'b0;
      @(posedge clk);
      #1;

      // Sequential fetch from reset, one word per cycle once filled.
      do_reset();
      dec_ready = 1'b1;
      lat = 1;
      repeat (10) tick();
      n0 = hs_total;
      repeat (10) tick();
      chk("t1_rate", 32'(hs_total - n0), 32'd10);

      // Decode stall: queue fills to DEPTH, requests stop, nothing lost on release.
      dec_ready = 1'b0;
      repeat (10) tick();
      chk("t2_buffered", 32'(exp_q.size()), 32'(DEPTH));
      chk("t2_req_low", {31'h0, imem_req}, 32'h0);
      chk("t2_valid", {31'h0, dec_valid}, 32'h1);
      dec_ready = 1'b1;
      repeat (12) tick();
      chk("t2_drained", 32'(hs_total - n0), 32'(hs_total - n0) > 32'd10 ? 32'(hs_total - n0) : 32'd11);

      // Redirect with two reads in flight and no response that cycle.
      lat = 3;
      repeat (8) tick();
      for (int i = 0; i < 20 && !(mem_due.size() == 2 && mem_due[0] > cyc); i++) tick();
      chk("t3_two_out", 32'(mem_due.size()), 32'd2);
      redir_pc    = 16'h4000;
      redir_valid = 1'b1;
      tick();
      redir_valid = 1'b0;
      chk("t3_flush_empty", {31'h0, dec_valid}, 32'h0);
      repeat (15) tick();
      chk("t3_first_seen", {31'h0, first_pend}, 32'h0);

      // Redirect coinciding with a response and a decode pop.
      lat = 1;
      repeat (10) tick();
      chk("t4_pop_setup", {31'h0, dec_valid}, 32'h1);
      chk("t4_resp_setup", {31'h0, (mem_due.size() > 0 && mem_due[0] <= cyc)}, 32'h1);
      redir_pc    = 16'h5000;
      redir_valid = 1'b1;
      tick();
      redir_valid = 1'b0;
      repeat (10) tick();
      chk("t4_first_seen", {31'h0, first_pend}, 32'h0);

      // Address wrap across 16'hFFFF.
      saw_zero    = 0;
      redir_pc    = 16'hFFFE;
      redir_valid = 1'b1;
      tick();
      redir_valid = 1'b0;
      repeat (12) tick();
      chk("t5_wrap_seen", {31'h0, saw_zero}, 32'h1);

      // Handshake counter and reset in the middle of a burst.
      do_reset();
      dec_ready = 1'b1;
      for (int i = 0; i < 40 && hs_since_rst < 7; i++) tick();
      dec_ready = 1'b0;
      chk("t6_hs7", 32'(hs_since_rst), 32'd7);
      tick();
`ifdef FETCH_PERF_EN
      chk("t6_cnt7", fetch_cnt, 32'd7);
`else
      chk("t6_cnt_off", fetch_cnt, 32'd0);
`endif
      dec_ready = 1'b1;
      repeat (3) tick();
      do_reset();
      repeat (10) tick();
      chk("t6_restart", {31'h0, first_pend}, 32'h0);
      chk("t6_cnt_after", fetch_cnt, exp_cnt());

      // Random decode back-pressure and latency with occasional redirects.
      for (int i = 0; i < 300; i++) begin
         dec_ready   = ($urandom_range(0, 3) != 0);
         lat         = $urandom_range(1, 4);
         redir_valid = ($urandom_range(0, 19) == 0);
         redir_pc    = 16'($urandom_range(0, 65535));
         tick();
      end
      redir_valid = 1'b0;
      dec_ready   = 1'b1;
      repeat (30) tick();
      chk("rand_drained", 32'(exp_q.size()) <= 32'(DEPTH + 2) ? 32'h1 : 32'h0, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
